// File: rtl/dram_cmd_responder.sv
// Device-side DRAM command responder: one command per req/ack handshake,
// per-bank open/row tracking, fixed per-command latency, protocol-error pulses.
module dram_cmd_responder #(
  parameter int NUMBER_OF_BANKS = 8,
  parameter int NUMBER_OF_ROWS  = 128,
  parameter int NUMBER_OF_COLS  = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int T_RCD           = 2,
  parameter int T_CAS           = 3,
  parameter int T_RP            = 2,
  parameter int T_RFC           = 6
) (
  input  logic                               clk,
  input  logic                               rst_b,
  input  logic                               cmd_req,
  input  logic [1:0]                         cmd,
  input  logic [$clog2(NUMBER_OF_BANKS)-1:0] bank_id,
  input  logic [$clog2(NUMBER_OF_ROWS)-1:0]  row_id,
  input  logic [$clog2(NUMBER_OF_COLS)-1:0]  col_id,
  output logic                               cmd_ack,
  output logic                               busy,
  output logic                               rd_valid,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic [NUMBER_OF_BANKS-1:0]         bank_open,
  output logic                               err,
  output logic [15:0]                        refresh_cnt
);

  localparam int BANK_W = $clog2(NUMBER_OF_BANKS);
  localparam int ROW_W  = $clog2(NUMBER_OF_ROWS);
  localparam int COL_W  = $clog2(NUMBER_OF_COLS);

  localparam logic [1:0] CMD_ACT  = 2'b00;
  localparam logic [1:0] CMD_READ = 2'b01;
  localparam logic [1:0] CMD_REF  = 2'b10;

  if (T_RCD < 1 || T_RCD > 255 || T_CAS < 1 || T_CAS > 255 ||
      T_RP < 1 || T_RP > 255 || T_RFC < 1 || T_RFC > 255) begin : g_bad_latency
    $error("dram_cmd_responder: latency parameters must lie in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t            state;
  logic [7:0]        timer;
  logic [1:0]        cmd_q;
  logic [BANK_W-1:0] bank_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_mem [NUMBER_OF_BANKS];

  function automatic logic [7:0] latency_of(input logic [1:0] c);
    logic [7:0] t;
    case (c)
      CMD_ACT:  t = 8'(T_RCD);
      CMD_READ: t = 8'(T_CAS);
      CMD_REF:  t = 8'(T_RFC);
      default:  t = 8'(T_RP);
    endcase
    return t;
  endfunction

  // Linear address of the cell, truncated to the data width.
  function automatic logic [DATA_WIDTH-1:0] read_word(input logic [BANK_W-1:0] b,
                                                      input logic [ROW_W-1:0]  r,
                                                      input logic [COL_W-1:0]  c);
    logic [31:0] addr;
    addr = 32'(b) * 32'(NUMBER_OF_ROWS * NUMBER_OF_COLS)
         + 32'(r) * 32'(NUMBER_OF_COLS) + 32'(c);
    return addr[DATA_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state       <= S_IDLE;
      timer       <= '0;
      cmd_q       <= '0;
      bank_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      cmd_ack     <= 1'b0;
      busy        <= 1'b0;
      rd_valid    <= 1'b0;
      err         <= 1'b0;
      rd_data     <= '0;
      bank_open   <= '0;
      refresh_cnt <= '0;
      for (int i = 0; i < NUMBER_OF_BANKS; i++) begin
        row_mem[i] <= '0;
      end
    end else begin
      cmd_ack  <= 1'b0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_req) begin
            cmd_q  <= cmd;
            bank_q <= bank_id;
            row_q  <= row_id;
            col_q  <= col_id;
            timer  <= latency_of(cmd);
            busy   <= 1'b1;
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (timer == 8'd1) begin
            // Command takes effect on the edge that enters ACK.
            state   <= S_ACK;
            cmd_ack <= 1'b1;
            case (cmd_q)
              CMD_ACT: begin
                err               <= bank_open[bank_q];
                bank_open[bank_q] <= 1'b1;
                row_mem[bank_q]   <= row_q;
              end
              CMD_READ: begin
                if (bank_open[bank_q] && (row_mem[bank_q] == row_q)) begin
                  rd_valid <= 1'b1;
                  rd_data  <= read_word(bank_q, row_q, col_q);
                end else begin
                  err <= 1'b1;
                end
              end
              CMD_REF: begin
                err         <= |bank_open;
                refresh_cnt <= refresh_cnt + 16'd1;
              end
              default: begin
                bank_open[bank_q] <= 1'b0;
              end
            endcase
          end else begin
            timer <= timer - 8'd1;
          end
        end
        S_ACK: begin
          busy  <= 1'b0;
          state <= S_RELEASE;
        end
        default: begin
          // Controller must return cmd_req to zero before the next command.
          if (!cmd_req) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Self-checking bench for dram_cmd_responder: an event-level model predicts
// every output each cycle; directed cases pin literal values from the test plan.
module tb_dram_cmd_responder;

  localparam int NB   = 8;
  localparam int NR   = 128;
  localparam int NC   = 8;
  localparam int TRCD = 2;
  localparam int TCAS = 3;
  localparam int TRP  = 2;
  localparam int TRFC = 6;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        cmd_req = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [2:0]  bank_id = '0;
  logic [6:0]  row_id = '0;
  logic [2:0]  col_id = '0;
  logic        cmd_ack;
  logic        busy;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [7:0]  bank_open;
  logic        err;
  logic [15:0] refresh_cnt;

  int checks = 0;
  int failures = 0;

  dram_cmd_responder #(
    .NUMBER_OF_BANKS(NB), .NUMBER_OF_ROWS(NR), .NUMBER_OF_COLS(NC), .DATA_WIDTH(8),
    .T_RCD(TRCD), .T_CAS(TCAS), .T_RP(TRP), .T_RFC(TRFC)
  ) dut (
    .clk(clk), .rst_b(rst_b), .cmd_req(cmd_req), .cmd(cmd), .bank_id(bank_id),
    .row_id(row_id), .col_id(col_id), .cmd_ack(cmd_ack), .busy(busy),
    .rd_valid(rd_valid), .rd_data(rd_data), .bank_open(bank_open), .err(err),
    .refresh_cnt(refresh_cnt)
  );

  always #5 clk = ~clk;

  // Event-level reference: a captured command completes exactly T edges later.
  int          edge_n = 0;
  int          ack_edge = -100;
  bit          m_init = 0;
  bit          pending = 0;
  bit          need_zero = 0;
  logic [1:0]  p_cmd;
  int          p_bank, p_row, p_col;
  bit          m_open [NB];
  int          m_row  [NB];
  logic        e_ack, e_busy, e_rdv, e_err;
  logic [7:0]  e_rd, e_open;
  logic [15:0] e_cnt;

  function automatic int lat_of(input logic [1:0] c);
    case (c)
      2'b00:   return TRCD;
      2'b01:   return TCAS;
      2'b10:   return TRFC;
      default: return TRP;
    endcase
  endfunction

  always @(posedge clk) begin
    int addr;
    bit any_open;
    edge_n++;
    if (rst_b) begin
      m_init = 1; pending = 0; need_zero = 0; ack_edge = -100;
      for (int i = 0; i < NB; i++) begin m_open[i] = 0; m_row[i] = 0; end
      e_ack = 0; e_rdv = 0; e_err = 0; e_rd = 0; e_cnt = 0;
    end else begin
      e_ack = 0; e_rdv = 0; e_err = 0;
      if (pending && edge_n == ack_edge) begin
        pending = 0; need_zero = 1; e_ack = 1;
        any_open = 0;
        for (int i = 0; i < NB; i++) any_open |= m_open[i];
        case (p_cmd)
          2'b00: begin e_err = m_open[p_bank]; m_open[p_bank] = 1; m_row[p_bank] = p_row; end
          2'b01: begin
            if (m_open[p_bank] && m_row[p_bank] == p_row) begin
              addr = p_bank * NR * NC + p_row * NC + p_col;
              e_rdv = 1; e_rd = 8'(addr % 256);
            end else e_err = 1;
          end
          2'b10: begin e_err = any_open; e_cnt = e_cnt + 16'd1; end
          default: m_open[p_bank] = 0;
        endcase
      end else if (need_zero) begin
        if (edge_n >= ack_edge + 2 && !cmd_req) need_zero = 0;
      end else if (!pending && cmd_req) begin
        pending = 1; p_cmd = cmd; p_bank = int'(bank_id); p_row = int'(row_id);
        p_col = int'(col_id); ack_edge = edge_n + lat_of(cmd);
      end
    end
    e_busy = pending || (edge_n == ack_edge);
    for (int i = 0; i < NB; i++) e_open[i] = m_open[i];
  end

  always @(negedge clk) begin
    if (m_init) begin
      checks++;
      if (cmd_ack !== e_ack || busy !== e_busy || rd_valid !== e_rdv || err !== e_err ||
          rd_data !== e_rd || bank_open !== e_open || refresh_cnt !== e_cnt) begin
        failures++;
        $display("FAIL model_cycle edge=%0d got ack=%b busy=%b rdv=%b err=%b rd=%h open=%b cnt=%0d want ack=%b busy=%b rdv=%b err=%b rd=%h open=%b cnt=%0d",
                 edge_n, cmd_ack, busy, rd_valid, err, rd_data, bank_open, refresh_cnt,
                 e_ack, e_busy, e_rdv, e_err, e_rd, e_open, e_cnt);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  logic [7:0]  r_rd, r_open;
  logic [15:0] r_cnt;
  logic        r_err, r_rdv;
  int          r_lat;

  task automatic do_cmd(input logic [1:0] c, input int b, input int r, input int cl,
                        input bit scramble, input int hold);
    int n;
    @(negedge clk);
    cmd_req = 1'b1; cmd = c; bank_id = 3'(b); row_id = 7'(r); col_id = 3'(cl);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (scramble && !cmd_ack) begin
        cmd = 2'($urandom); bank_id = 3'($urandom); row_id = 7'($urandom); col_id = 3'($urandom);
      end
    end while (!cmd_ack && n < 40);
    if (!cmd_ack) begin
      checks++; failures++;
      $display("FAIL ack_timeout got=no_ack want=ack_within_40");
    end
    r_lat = n; r_err = err; r_rdv = rd_valid; r_rd = rd_data; r_open = bank_open; r_cnt = refresh_cnt;
    repeat (hold) begin
      @(negedge clk);
      check("no_ack_while_req_high", int'(cmd_ack), 0);
    end
    cmd_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_ack", int'(cmd_ack), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_open", int'(bank_open), 0);
    check("reset_cnt", int'(refresh_cnt), 0);
    check("reset_rd", int'(rd_data), 0);
    rst_b = 1'b0;

    do_cmd(2'b00, 3, 5, 0, 0, 0);
    check("act_latency", r_lat, TRCD + 1);
    check("act_open", int'(r_open), 8'b0000_1000);
    check("act_err", int'(r_err), 0);

    do_cmd(2'b01, 3, 5, 6, 0, 0);
    check("read_latency", r_lat, TCAS + 1);
    check("read_hit_valid", int'(r_rdv), 1);
    check("read_hit_data", int'(r_rd), 8'h2E);
    do_cmd(2'b01, 3, 7, 0, 0, 0);
    check("read_miss_err", int'(r_err), 1);
    check("read_miss_valid", int'(r_rdv), 0);
    check("read_miss_hold", int'(r_rd), 8'h2E);

    do_cmd(2'b10, 0, 0, 0, 0, 0);
    check("ref_open_err", int'(r_err), 1);
    check("ref_open_cnt", int'(r_cnt), 1);
    do_cmd(2'b11, 3, 0, 0, 0, 0);
    check("pre_err", int'(r_err), 0);
    do_cmd(2'b10, 0, 0, 0, 0, 0);
    check("ref_closed_err", int'(r_err), 0);
    check("ref_closed_cnt", int'(r_cnt), 2);
    check("ref_closed_open", int'(r_open), 0);

    do_cmd(2'b00, 1, 9, 0, 1, 4);
    check("latched_act_open", int'(r_open), 8'b0000_0010);
    do_cmd(2'b01, 1, 9, 2, 1, 0);
    check("latched_read_valid", int'(r_rdv), 1);
    check("latched_read_data", int'(r_rd), 8'h4A);

    do_cmd(2'b00, 0, 1, 0, 0, 0);
    check("act1_err", int'(r_err), 0);
    do_cmd(2'b00, 0, 2, 0, 0, 0);
    check("double_act_err", int'(r_err), 1);
    do_cmd(2'b01, 0, 2, 0, 0, 0);
    check("dbl_read_new_row", int'(r_rdv), 1);
    check("dbl_read_new_data", int'(r_rd), 8'h10);
    do_cmd(2'b01, 0, 1, 0, 0, 0);
    check("dbl_read_old_err", int'(r_err), 1);
    check("dbl_read_old_valid", int'(r_rdv), 0);

    @(negedge clk);
    cmd_req = 1'b1; cmd = 2'b10;
    repeat (2) @(negedge clk);
    check("mid_ref_busy", int'(busy), 1);
    rst_b = 1'b1; cmd_req = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_open", int'(bank_open), 0);
    check("mid_rst_cnt", int'(refresh_cnt), 0);
    check("mid_rst_rd", int'(rd_data), 0);
    repeat (10) begin
      @(negedge clk);
      check("mid_rst_no_ack", int'(cmd_ack), 0);
    end

    for (int k = 0; k < 250; k++) begin
      do_cmd(2'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
